complex_multiplier_seq: RTL and testbench

Sequential complex multiplier for the complex-arithmetic datapath. It multiplies two N-bit complex operands, (areal + j·aimaginary) × (breal + j·bimaginary), using a shift-and-add/subtract iteration over N cycles. It shares the wrap-around modulo-2^N arithmetic of the complex add/subtract unit, so the two blocks' results compose directly. A start/busy/done handshake lets a controller sequence it alongside that unit.

---
 rtl/complex_multiplier_seq.sv | 97 +++++++++
 tb/tb_complex_multiplier_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/complex_multiplier_seq.sv
// complex_multiplier_seq: sequential complex multiplier, one operand bit per cycle.
// Result = A * B mod 2^N for both parts, with a start/busy/done handshake.
module complex_multiplier_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] areal,
    input  logic [N-1:0] aimaginary,
    input  logic [N-1:0] breal,
    input  logic [N-1:0] bimaginary,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] resultreal,
    output logic [N-1:0] resultimaginary
);

    localparam int KW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  ar, ai, br, bi;
    logic [N-1:0]  accr, acci, accr_nxt, acci_nxt;
    logic [N-1:0]  ar_sh, ai_sh;
    logic [KW-1:0] k;
    logic          last, accept;

    assign last   = (k == KW'(N - 1));
    // A new operation can start from IDLE or straight out of DONE
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One partial-product step for bit k; shifts truncate to N bits (mod 2^N)
    always_comb begin
        ar_sh    = ar << k;
        ai_sh    = ai << k;
        accr_nxt = accr + (br[k] ? ar_sh : '0) - (bi[k] ? ai_sh : '0);
        acci_nxt = acci + (br[k] ? ai_sh : '0) + (bi[k] ? ar_sh : '0);
    end

    // Operand latch, accumulators and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar   <= '0;
            ai   <= '0;
            br   <= '0;
            bi   <= '0;
            accr <= '0;
            acci <= '0;
            k    <= '0;
        end else if (accept) begin
            ar   <= areal;
            ai   <= aimaginary;
            br   <= breal;
            bi   <= bimaginary;
            accr <= '0;
            acci <= '0;
            k    <= '0;
        end else if (state == RUN) begin
            accr <= accr_nxt;
            acci <= acci_nxt;
            k    <= k + 1'b1;
        end
    end

    // Results load on the final step and hold until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultreal      <= '0;
            resultimaginary <= '0;
        end else if (state == RUN && last) begin
            resultreal      <= accr_nxt;
            resultimaginary <= acci_nxt;
        end
    end

endmodule

// File: tb/tb_complex_multiplier_seq.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops on done.
module tb_complex_multiplier_seq;
    localparam int N = 8;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         start = 0;
    logic [N-1:0] areal = 0, aimaginary = 0, breal = 0, bimaginary = 0;
    logic         busy, done;
    logic [N-1:0] resultreal, resultimaginary;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] exp_q[$];

    complex_multiplier_seq #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .areal(areal), .aimaginary(aimaginary), .breal(breal), .bimaginary(bimaginary),
        .busy(busy), .done(done),
        .resultreal(resultreal), .resultimaginary(resultimaginary)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: flag exclusivity every cycle, pop and compare on each done
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_exclusive", int'(busy && done), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got result %0d+%0dj expected no done",
                             resultreal, resultimaginary);
                end else begin
                    logic [2*N-1:0] e;
                    e = exp_q.pop_front();
                    chk("resultreal", int'(resultreal), int'(e[2*N-1:N]));
                    chk("resultimaginary", int'(resultimaginary), int'(e[N-1:0]));
                end
            end
        end
    end

    task automatic set_ops(input int a_r, input int a_i, input int b_r, input int b_i);
        areal = N'(a_r); aimaginary = N'(a_i); breal = N'(b_r); bimaginary = N'(b_i);
    endtask

    // Issue one operation, check latency and busy length; glitch re-pulses start at cycle 3
    task automatic run_op(input int a_r, input int a_i, input int b_r, input int b_i,
                          input int e_r, input int e_i, input bit glitch);
        int cyc, busy_cnt, done_cyc;
        @(negedge clk);
        set_ops(a_r, a_i, b_r, b_i);
        start = 1;
        @(posedge clk);
        exp_q.push_back({N'(e_r), N'(e_i)});
        #1;
        busy_cnt = busy ? 1 : 0;
        done_cyc = -1;
        @(negedge clk);
        start = 0;
        set_ops(0, 0, 0, 0);
        for (cyc = 1; cyc <= N + 4; cyc++) begin
            @(posedge clk); #1;
            if (glitch && cyc == 2) begin
                set_ops(9, 7, 5, 3);
                start = 1;
            end
            if (glitch && cyc == 3) start = 0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk("done_latency", done_cyc, N);
        chk("busy_cycles", busy_cnt, N);
        @(posedge clk); #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int gap;
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rr", int'(resultreal), 0);
        chk("reset_ri", int'(resultimaginary), 0);
        @(negedge clk);
        rst_n = 1;
        idle_cycles(2);

        // Basic, wrap with -1, overflow wrap
        run_op(3, 2, 4, 5, 2, 23, 0);
        run_op(1, 1, 1, 255, 2, 0, 0);
        run_op(16, 0, 16, 16, 0, 0, 0);
        chk("result_hold_rr", int'(resultreal), 0);

        // start while busy is ignored; the monitor catches any second done
        run_op(2, 0, 3, 0, 6, 0, 1);
        idle_cycles(N + 4);
        chk("hold_after_ignore_rr", int'(resultreal), 6);

        // Back-to-back with start held through the DONE cycle
        @(negedge clk);
        set_ops(1, 2, 3, 4);
        start = 1;
        @(posedge clk);
        exp_q.push_back({N'(251), N'(10)});
        @(negedge clk);
        set_ops(1, 2, 1, 0);
        gap = 0;
        while (!done && gap < 3 * N) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_first_done", int'(done), 1);
        @(posedge clk);
        exp_q.push_back({N'(1), N'(2)});
        @(negedge clk);
        start = 0;
        gap = 1;
        while (!done && gap < 3 * N) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_second_done", int'(done), 1);
        chk("b2b_gap_ok", int'(gap == N || gap == N + 1), 1);
        idle_cycles(N + 2);

        // Reset in the middle of a run
        @(negedge clk);
        set_ops(3, 2, 4, 5);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        idle_cycles(4);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_rr", int'(resultreal), 0);
        chk("midrst_ri", int'(resultimaginary), 0);
        @(negedge clk);
        rst_n = 1;
        gap = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) gap++;
        end
        chk("midrst_no_activity", gap, 0);
        chk("midrst_rr_after", int'(resultreal), 0);
        chk("midrst_ri_after", int'(resultimaginary), 0);
        run_op(3, 2, 4, 5, 2, 23, 0);

        idle_cycles(4);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
